// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: sequenced wide equality comparator, one slice per cycle.
// Optional macro CMP_SEQ_EARLY_EXIT_EN: stop scanning at first mismatch.
module cmp_seq_ctrl #(
    parameter int WIDTH = 128,
    parameter int SLICE = 32,
    localparam int SLICES = WIDTH / SLICE,
    localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eq,
    output logic [IDXW-1:0]  out_idx,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IDXW-1:0]  cnt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc;
    logic             mm;
    logic [IDXW-1:0]  idx;
    logic             eq_r;
    logic [IDXW-1:0]  idx_r;

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic             eq_k;
    logic             last;
    logic             leave;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_eq    = eq_r;
    assign out_idx   = idx_r;

    // Select the current slice of both operands into one shared comparator.
    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < SLICES; i++) begin
            if (cnt == IDXW'(i)) begin
                sa = a[i*SLICE +: SLICE];
                sb = b[i*SLICE +: SLICE];
            end
        end
    end

    assign eq_k = (sa == sb);
    assign last = (cnt == IDXW'(SLICES - 1));

`ifdef CMP_SEQ_EARLY_EXIT_EN
    assign leave = last || !eq_k;
`else
    assign leave = last;
`endif

    // Controller: accept, scan slices, hold the verdict until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            acc   <= 1'b1;
            mm    <= 1'b0;
            idx   <= '0;
            eq_r  <= 1'b0;
            idx_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a     <= d1;
                        b     <= d2;
                        cnt   <= '0;
                        acc   <= 1'b1;
                        mm    <= 1'b0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc & eq_k;
                    if (!eq_k && !mm) begin
                        idx <= cnt;
                        mm  <= 1'b1;
                    end
                    if (!last) begin
                        cnt <= cnt + IDXW'(1);
                    end
                    if (leave) begin
                        eq_r  <= acc & eq_k;
                        idx_r <= (!mm && !eq_k) ? cnt : idx;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: randomized and directed checks against a slice-level model.
// Covers 128/32 and 8/8 configurations, with or without early exit.
module tb_cmp_seq_ctrl;

`ifdef CMP_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] d1;
    logic [127:0] d2;
    logic         in_ready;
    logic         out_valid;
    logic         out_eq;
    logic [1:0]   out_idx;
    logic         busy;

    logic         v8;
    logic         r8;
    logic [7:0]   a8;
    logic [7:0]   b8;
    logic         ir8;
    logic         ov8;
    logic         eq8;
    logic [0:0]   idx8;
    logic         busy8;

    int tests = 0;
    int fails = 0;

    cmp_seq_ctrl #(.WIDTH(128), .SLICE(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .d1(d1), .d2(d2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_eq(out_eq), .out_idx(out_idx), .busy(busy)
    );

    cmp_seq_ctrl #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(ir8),
        .d1(a8), .d2(b8),
        .out_valid(ov8), .out_ready(r8),
        .out_eq(eq8), .out_idx(idx8), .busy(busy8)
    );

    // Reference: compare 32-bit slices of the whole operands.
    function automatic void model(input logic [127:0] a, input logic [127:0] b,
                                  output bit eq, output int idx, output int lat);
        eq = (a == b);
        idx = 0;
        for (int k = 3; k >= 0; k--) begin
            if (a[k*32 +: 32] != b[k*32 +: 32]) idx = k;
        end
        lat = (EARLY && !eq) ? idx + 1 : 4;
    endfunction

    // Drive one request from a point #1 after a rising edge, collect result.
    task automatic transact(input logic [127:0] a, input logic [127:0] b,
                            input int hold, output int lat, output logic eq,
                            output logic [1:0] idx, output logic rdy);
        d1 = a;
        d2 = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        eq = out_eq;
        idx = out_idx;
        rdy = in_ready;
        repeat (hold) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++;
        if ({out_valid, out_eq, out_idx, busy, in_ready} !== 6'b0_0_00_0_1) begin
            fails++;
            $display("FAIL reset128 got=%b want=000001",
                     {out_valid, out_eq, out_idx, busy, in_ready});
        end
        tests++;
        if ({ov8, eq8, idx8, busy8, ir8} !== 5'b0_0_0_0_1) begin
            fails++;
            $display("FAIL reset8 got=%b want=00001", {ov8, eq8, idx8, busy8, ir8});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [127:0] base;
        logic [127:0] b;
        int lat;
        logic eq;
        logic [1:0] idx;
        logic rdy;
        base = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98;
        transact(base, base, 0, lat, eq, idx, rdy);
        tests++;
        if (lat !== 4 || eq !== 1'b1 || idx !== 2'd0 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL equal lat=%0d eq=%b idx=%0d rdy=%b want 4 1 0 0",
                     lat, eq, idx, rdy);
        end
        b = base ^ (128'd1 << 70);
        transact(base, b, 1, lat, eq, idx, rdy);
        tests++;
        if (lat !== (EARLY ? 3 : 4) || eq !== 1'b0 || idx !== 2'd2) begin
            fails++;
            $display("FAIL slice2 lat=%0d eq=%b idx=%0d want %0d 0 2",
                     lat, eq, idx, EARLY ? 3 : 4);
        end
        b = base ^ (128'd1 << 33) ^ (128'd1 << 100);
        transact(base, b, 2, lat, eq, idx, rdy);
        tests++;
        if (lat !== (EARLY ? 2 : 4) || eq !== 1'b0 || idx !== 2'd1) begin
            fails++;
            $display("FAIL slice1_3 lat=%0d eq=%b idx=%0d want %0d 0 1",
                     lat, eq, idx, EARLY ? 2 : 4);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a;
        logic [127:0] b;
        int lat;
        bit stable;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = a ^ (128'd1 << 97);
        d1 = a;
        d2 = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        d1 = ~a;
        d2 = ~a;
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL bp_latency got=%0d want=4", lat);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_eq !== 1'b0 || out_idx !== 2'd3 ||
                in_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        tests++;
        if (stable !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold got=%b want=1", stable);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL bp_handshake got=%b want=010", {out_valid, in_ready, busy});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if ({in_ready, busy} !== 2'b01) begin
            fails++;
            $display("FAIL bp_accept got=%b want=01", {in_ready, busy});
        end
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== 4 || out_eq !== 1'b1 || out_idx !== 2'd0) begin
            fails++;
            $display("FAIL bp_second lat=%0d eq=%b idx=%0d want 4 1 0",
                     lat, out_eq, out_idx);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] a;
        int lat;
        logic eq;
        logic [1:0] idx;
        logic rdy;
        a = {$urandom, $urandom, $urandom, $urandom};
        d1 = a;
        d2 = a ^ 128'h1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL midrun_reset got=%b want=010", {out_valid, in_ready, busy});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrun_stale got=%b want=0", out_valid);
        end
        transact(a, a, 0, lat, eq, idx, rdy);
        tests++;
        if (lat !== 4 || eq !== 1'b1 || idx !== 2'd0) begin
            fails++;
            $display("FAIL midrun_after lat=%0d eq=%b idx=%0d want 4 1 0", lat, eq, idx);
        end
    endtask

    task automatic test_back_to_back();
        int rise[$];
        logic prev;
        logic [127:0] a;
        a = {$urandom, $urandom, $urandom, $urandom};
        d1 = a;
        d2 = a;
        in_valid = 1'b1;
        out_ready = 1'b1;
        prev = out_valid;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid && !prev) rise.push_back(i);
            prev = out_valid;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if (rise.size() < 2 || rise[1] - rise[0] != 6) begin
            fails++;
            $display("FAIL b2b_period rises=%0d gap=%0d want gap 6", rise.size(),
                     rise.size() >= 2 ? rise[1] - rise[0] : -1);
        end
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_drain got=%b want=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_random();
        logic [127:0] a;
        logic [127:0] b;
        int lat;
        logic eq;
        logic [1:0] idx;
        logic rdy;
        bit meq;
        int midx;
        int mlat;
        for (int n = 0; n < 40; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = a;
            case ($urandom_range(0, 2))
                0: b = a;
                1: begin
                    for (int k = 0; k < 4; k++) begin
                        if ($urandom_range(0, 1) == 1)
                            b[k*32 + $urandom_range(0, 31)] ^= 1'b1;
                    end
                end
                default: b = {$urandom, $urandom, $urandom, $urandom};
            endcase
            model(a, b, meq, midx, mlat);
            transact(a, b, $urandom_range(0, 3), lat, eq, idx, rdy);
            tests++;
            if (lat !== mlat || eq !== meq || idx !== 2'(midx) || rdy !== 1'b0) begin
                fails++;
                $display("FAIL random%0d lat=%0d eq=%b idx=%0d rdy=%b want %0d %b %0d 0",
                         n, lat, eq, idx, rdy, mlat, meq, midx);
            end
        end
    endtask

    task automatic test_single_slice();
        int lat;
        for (int t = 0; t < 2; t++) begin
            a8 = 8'hA5;
            b8 = (t == 0) ? 8'hA4 : 8'hA5;
            v8 = 1'b1;
            @(posedge clk); #1;
            v8 = 1'b0;
            lat = 0;
            while (!ov8 && lat < 16) begin
                @(posedge clk); #1;
                lat++;
            end
            tests++;
            if (lat !== 1 || eq8 !== (t == 1) || idx8 !== 1'b0) begin
                fails++;
                $display("FAIL slice8_%0d lat=%0d eq=%b idx=%0d want 1 %0d 0",
                         t, lat, eq8, idx8, t);
            end
            r8 = 1'b1;
            @(posedge clk); #1;
            r8 = 1'b0;
            tests++;
            if ({ov8, ir8} !== 2'b01) begin
                fails++;
                $display("FAIL slice8_hs%0d got=%b want=01", t, {ov8, ir8});
            end
        end
    endtask

    initial begin
        in_valid = 1'b0;
        out_ready = 1'b0;
        d1 = '0;
        d2 = '0;
        v8 = 1'b0;
        r8 = 1'b0;
        a8 = '0;
        b8 = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_single_slice();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
- Sequenced wide equality comparator for narrow-area builds.
- Captures two WIDTH-bit operands, then compares one SLICE-bit slice per cycle, starting from the LSB slice, through a single shared slice-equality datapath.
- Accumulates a running AND of the slice results and returns the verdict plus the index of the first mismatching slice.
- Valid/ready on both sides; sits between the request source (e.g. key-match logic) and its consumer.

Parameters:
- WIDTH, 128, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 32, bits compared per cycle; power of two, 1 <= SLICE <= WIDTH.
- SLICES, WIDTH/SLICE, derived; not to be overridden.
- IDXW, max(1, clog2(SLICES)), derived; width of the slice index.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request; high only in IDLE.
- d1  input  WIDTH  operand A; sampled on the accepting edge only.
- d2  input  WIDTH  operand B; sampled on the accepting edge only.
- out_valid  output  1  result present; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_eq  output  1  1 when d1 == d2 over all WIDTH bits.
- out_idx  output  IDXW  lowest mismatching slice index; 0 when out_eq = 1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, slice counter = 0, operand registers = 0, eq accumulator = 1. Outputs: out_valid = 0, out_eq = 0, out_idx = 0, busy = 0, in_ready = 1. Inputs are ignored while rst_n is low.
- Reset mid-operation: the transaction is discarded and no out_valid is produced. First accept is possible on the first edge after rst_n deasserts.
- FSM state IDLE:
  - in_ready = 1.
  - in_valid && in_ready at an edge: capture d1/d2, counter = 0, accumulator = 1, first-mismatch flag = 0; go to RUN.
- FSM state RUN:
  - Each edge evaluates slice k = counter: eq_k = (A[k*SLICE +: SLICE] == B[k*SLICE +: SLICE]).
  - accumulator <= accumulator & eq_k.
  - On the first eq_k = 0, record k into the index register and set the first-mismatch flag. Later mismatches do not overwrite it.
  - Counter increments by 1 per edge.
  - Leave RUN when k = SLICES-1 (counter does not wrap past SLICES-1). With CMP_SEQ_EARLY_EXIT_EN, also leave when eq_k = 0.
  - On leaving: out_eq <= final accumulator; out_idx <= recorded index (0 if none); go to DONE.
- FSM state DONE:
  - out_valid = 1; out_eq and out_idx hold stable until the handshake.
  - out_valid && out_ready at an edge: go to IDLE, out_valid drops.
  - out_ready low: hold indefinitely.
- Latency: edge E0 accepts. The slice k compare happens at edge E(k+1). out_valid is high after edge E(SLICES) (full scan).
  - SLICES = 4: out_valid is high 4 cycles after accept.
  - SLICES = 1: 1 cycle.
- Throughput: at least one idle bubble between results, because in_ready is low in DONE. Max rate is 1 result per SLICES+2 cycles.
- in_valid asserted while busy: ignored, held by the source, not dropped.
- out_ready asserted before out_valid: no effect.

Optional Feature:
- Macro: CMP_SEQ_EARLY_EXIT_EN.
- Defined: RUN terminates on the first mismatching slice k, and out_valid is high after edge E(k+1). Equal operands still take SLICES cycles.
- Undefined: all SLICES slices are always scanned, giving fixed, data-independent latency (timing-side-channel safe).
- out_eq and out_idx values are identical in both builds.

Test Plan:
- Equal operands: WIDTH=128, SLICE=32, d1 = d2 = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEDC_BA98 -> out_valid 4 cycles after accept, out_eq = 1, out_idx = 0.
- Mismatch in slice 2 only (d2 = d1 ^ (1 << 70)) -> out_eq = 0, out_idx = 2. Latency is 4 cycles without EARLY_EXIT and 3 cycles with it.
- Mismatches in slices 1 and 3 (bits 33 and 100 flipped) -> out_idx = 1. Without EARLY_EXIT, latency is 4; with it, 2.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> out_valid, out_eq and out_idx stay stable, in_ready stays 0, and a pending in_valid is not accepted until 1 cycle after the result handshake.
- Reset mid-RUN: pull rst_n low after the second slice edge -> out_valid = 0 and in_ready = 1 immediately. A new equal-operand request after release returns out_eq = 1 with no stale result.
- SLICE = WIDTH = 8, d1 = 8'hA5, d2 = 8'hA4 -> out_valid 1 cycle after accept, out_eq = 0, out_idx = 0.
